secuenciador_lectura_ventana: RTL and testbench

SECUENCIADOR_LECTURA_VENTANA -- requirements
Module: secuenciador_lectura_ventana

---
 rtl/secuenciador_lectura_ventana_pkg.sv | 18 +
 rtl/secuenciador_lectura_ventana_if.sv | 41 ++++
 rtl/secuenciador_lectura_ventana_contador_lineas_buffer.sv | 70 +++++++
 rtl/secuenciador_lectura_ventana.sv | 118 +++++++++++
 tb/tb_secuenciador_lectura_ventana.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/secuenciador_lectura_ventana_pkg.sv
// Shared definitions for the windowed memory read sequencer.
// Holds default widths and the FSM state encoding.
package secuenciador_lectura_ventana_pkg;

    localparam int P_BITS_DIRECCION_MEM   = 10;
    localparam int P_BITS_BUS_DATOS_INSTR = 24;
    localparam int P_BITS_BUFFERS         = 3;
    localparam int P_BITS_DATOS_MEM       = 32;
    localparam int P_PALABRAS_POR_LINEA   = 128;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        SOLICITAR = 2'd1,
        ESPERAR   = 2'd2,
        FIN       = 2'd3
    } estado_t;

endpackage

// File: rtl/secuenciador_lectura_ventana_if.sv
// Memory read and buffer write signals of the sequencer.
// master = sequencer side, slave = memory/buffer side.
interface secuenciador_lectura_ventana_if
    import secuenciador_lectura_ventana_pkg::*;
#(
    parameter int BITS_DIRECCION_MEM = P_BITS_DIRECCION_MEM,
    parameter int BITS_DATOS_MEM     = P_BITS_DATOS_MEM,
    parameter int BITS_BUFFERS       = P_BITS_BUFFERS
);
    logic                          solicitud_lectura;
    logic [BITS_DIRECCION_MEM-1:0] direccion_lectura;
    logic                          dato_valido_mem;
    logic [BITS_DATOS_MEM-1:0]     datos_mem;
    logic                          buffer_lleno;
    logic                          escritura_buffer;
    logic [BITS_DATOS_MEM-1:0]     datos_buffer;
    logic [BITS_BUFFERS-1:0]       seleccion_buffer;

    modport master (
        output solicitud_lectura,
        output direccion_lectura,
        input  dato_valido_mem,
        input  datos_mem,
        input  buffer_lleno,
        output escritura_buffer,
        output datos_buffer,
        output seleccion_buffer
    );

    modport slave (
        input  solicitud_lectura,
        input  direccion_lectura,
        output dato_valido_mem,
        output datos_mem,
        output buffer_lleno,
        input  escritura_buffer,
        input  datos_buffer,
        input  seleccion_buffer
    );

endinterface

// File: rtl/secuenciador_lectura_ventana_contador_lineas_buffer.sv
// Word, column and buffer-select counters for the sequencer.
// Rotates the buffer select every line and flags the last word.
module contador_lineas_buffer
    import secuenciador_lectura_ventana_pkg::*;
#(
    parameter int BITS_PALABRAS      = P_BITS_BUS_DATOS_INSTR,
    parameter int BITS_BUFFERS       = P_BITS_BUFFERS,
    parameter int PALABRAS_POR_LINEA = P_PALABRAS_POR_LINEA
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     limpiar_i,
    input  logic                     avanzar_i,
    input  logic [BITS_PALABRAS-1:0] total_i,
    input  logic [BITS_BUFFERS-1:0]  buffers_i,
    output logic [BITS_BUFFERS-1:0]  seleccion_o,
    output logic                     ultima_o
);

    localparam int BITS_COLUMNA =
        (PALABRAS_POR_LINEA > 1) ? $clog2(PALABRAS_POR_LINEA) : 1;
    localparam logic [BITS_COLUMNA-1:0] COLUMNA_MAX =
        BITS_COLUMNA'(PALABRAS_POR_LINEA - 1);

    logic [BITS_PALABRAS-1:0] palabras_q, palabras_d, palabras_mas1;
    logic [BITS_COLUMNA-1:0]  columna_q, columna_d;
    logic [BITS_BUFFERS-1:0]  seleccion_q, seleccion_d;
    logic [BITS_BUFFERS-1:0]  ultimo_buffer;

    // Next counter values; a buffer count of 0 behaves as one buffer
    always_comb begin
        palabras_mas1 = palabras_q + BITS_PALABRAS'(1);
        ultimo_buffer = (buffers_i == '0) ? '0
                      : buffers_i - BITS_BUFFERS'(1);
        palabras_d    = palabras_q;
        columna_d     = columna_q;
        seleccion_d   = seleccion_q;
        if (limpiar_i) begin
            palabras_d  = '0;
            columna_d   = '0;
            seleccion_d = '0;
        end else if (avanzar_i) begin
            palabras_d = palabras_mas1;
            if (columna_q == COLUMNA_MAX) begin
                columna_d   = '0;
                seleccion_d = (seleccion_q >= ultimo_buffer) ? '0
                            : seleccion_q + BITS_BUFFERS'(1);
            end else begin
                columna_d = columna_q + BITS_COLUMNA'(1);
            end
        end
    end

    // Counter state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            palabras_q  <= '0;
            columna_q   <= '0;
            seleccion_q <= '0;
        end else begin
            palabras_q  <= palabras_d;
            columna_q   <= columna_d;
            seleccion_q <= seleccion_d;
        end
    end

    assign seleccion_o = seleccion_q;
    assign ultima_o    = (palabras_mas1 == total_i);

endmodule

// File: rtl/secuenciador_lectura_ventana.sv
// Sequencer that reads a run of memory words, one at a time,
// and streams them into a rotating set of internal buffers.
module secuenciador_lectura_ventana
    import secuenciador_lectura_ventana_pkg::*;
#(
    parameter int BITS_DIRECCION_MEM   = P_BITS_DIRECCION_MEM,
    parameter int BITS_BUS_DATOS_INSTR = P_BITS_BUS_DATOS_INSTR,
    parameter int BITS_BUFFERS         = P_BITS_BUFFERS,
    parameter int BITS_DATOS_MEM       = P_BITS_DATOS_MEM,
    parameter int PALABRAS_POR_LINEA   = P_PALABRAS_POR_LINEA
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            inicio,
    input  logic                            cancelar,
    input  logic [BITS_DIRECCION_MEM-1:0]   direccion_mem_inicio_imagen,
    input  logic [BITS_BUS_DATOS_INSTR-1:0] cantidad_lecturas_mem,
    input  logic [BITS_BUFFERS-1:0]         cantidad_buffers_internos,
    secuenciador_lectura_ventana_if.master  bus,
    output logic                            ocupado,
    output logic                            listo
);

    estado_t                         estado_q, estado_d;
    logic [BITS_DIRECCION_MEM-1:0]   direccion_q, direccion_d;
    logic [BITS_BUS_DATOS_INSTR-1:0] total_q, total_d;
    logic [BITS_BUFFERS-1:0]         buffers_q, buffers_d;

    logic                    arranque;
    logic                    peticion;
    logic                    escritura;
    logic                    ultima;
    logic [BITS_BUFFERS-1:0] seleccion;

    // Handshake decodes; an abort suppresses both request and write
    always_comb begin
        arranque  = (estado_q == REPOSO) && inicio;
        peticion  = (estado_q == SOLICITAR) && !bus.buffer_lleno
                 && !cancelar;
        escritura = (estado_q == ESPERAR) && bus.dato_valido_mem
                 && !cancelar;
    end

    // Next state and configuration/address registers
    always_comb begin
        estado_d    = estado_q;
        direccion_d = direccion_q;
        total_d     = total_q;
        buffers_d   = buffers_q;
        unique case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    direccion_d = direccion_mem_inicio_imagen;
                    total_d     = cantidad_lecturas_mem;
                    buffers_d   = cantidad_buffers_internos;
                    estado_d    = (cantidad_lecturas_mem == '0) ? FIN
                                : SOLICITAR;
                end
            end
            SOLICITAR: begin
                if (cancelar)
                    estado_d = REPOSO;
                else if (!bus.buffer_lleno)
                    estado_d = ESPERAR;
            end
            ESPERAR: begin
                if (cancelar) begin
                    estado_d = REPOSO;
                end else if (bus.dato_valido_mem) begin
                    direccion_d = direccion_q
                                + BITS_DIRECCION_MEM'(1);
                    estado_d    = ultima ? FIN : SOLICITAR;
                end
            end
            FIN:     estado_d = REPOSO;
            default: estado_d = REPOSO;
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q    <= REPOSO;
            direccion_q <= '0;
            total_q     <= '0;
            buffers_q   <= '0;
        end else begin
            estado_q    <= estado_d;
            direccion_q <= direccion_d;
            total_q     <= total_d;
            buffers_q   <= buffers_d;
        end
    end

    contador_lineas_buffer #(
        .BITS_PALABRAS      (BITS_BUS_DATOS_INSTR),
        .BITS_BUFFERS       (BITS_BUFFERS),
        .PALABRAS_POR_LINEA (PALABRAS_POR_LINEA)
    ) u_contador (
        .clk         (clk),
        .reset       (reset),
        .limpiar_i   (arranque),
        .avanzar_i   (escritura),
        .total_i     (total_q),
        .buffers_i   (buffers_q),
        .seleccion_o (seleccion),
        .ultima_o    (ultima)
    );

    assign bus.solicitud_lectura = peticion;
    assign bus.direccion_lectura = direccion_q;
    assign bus.escritura_buffer  = escritura;
    assign bus.datos_buffer      = escritura ? bus.datos_mem : '0;
    assign bus.seleccion_buffer  = seleccion;
    assign ocupado               = (estado_q != REPOSO);
    assign listo                 = (estado_q == FIN);

endmodule

// File: tb/tb_secuenciador_lectura_ventana.sv
// Bench for secuenciador_lectura_ventana: directed transfers,
// 1-cycle memory model, queue scoreboard checked by a monitor.
module tb_secuenciador_lectura_ventana;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inicio = 1'b0;
    logic        cancelar = 1'b0;
    logic [9:0]  dir_ini = '0;
    logic [23:0] cantidad = '0;
    logic [2:0]  nbuf = '0;
    logic        ocupado;
    logic        listo;

    secuenciador_lectura_ventana_if #(
        .BITS_DIRECCION_MEM (10),
        .BITS_DATOS_MEM     (32),
        .BITS_BUFFERS       (3)
    ) bus ();

    secuenciador_lectura_ventana #(
        .BITS_DIRECCION_MEM   (10),
        .BITS_BUS_DATOS_INSTR (24),
        .BITS_BUFFERS         (3),
        .BITS_DATOS_MEM       (32),
        .PALABRAS_POR_LINEA   (2)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .inicio                      (inicio),
        .cancelar                    (cancelar),
        .direccion_mem_inicio_imagen (dir_ini),
        .cantidad_lecturas_mem       (cantidad),
        .cantidad_buffers_internos   (nbuf),
        .bus                         (bus),
        .ocupado                     (ocupado),
        .listo                       (listo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  s;
    } esc_t;

    logic [9:0] exp_dir[$];
    esc_t       exp_esc[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         listo_cnt = 0;
    int         listo_exp = 0;
    int         rd_idx = 0;
    int         cancel_at = -1;
    bit         mon_en = 1'b1;
    bit         prev_listo = 1'b0;

    function automatic logic [31:0] dato_de(logic [9:0] a);
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(logic [9:0] a, logic [2:0] s);
        esc_t e;
        exp_dir.push_back(a);
        e.d = dato_de(a);
        e.s = s;
        exp_esc.push_back(e);
    endtask

    // Memory: answers a request seen this cycle in the next cycle
    initial begin
        logic [9:0] a;
        bus.dato_valido_mem = 1'b0;
        bus.datos_mem       = '0;
        forever begin
            @(negedge clk);
            if (reset && bus.solicitud_lectura) begin
                a = bus.direccion_lectura;
                @(posedge clk);
                #1;
                bus.dato_valido_mem = 1'b1;
                bus.datos_mem       = dato_de(a);
                if (rd_idx == cancel_at)
                    cancelar = 1'b1;
                rd_idx++;
                @(posedge clk);
                #1;
                bus.dato_valido_mem = 1'b0;
                bus.datos_mem       = '0;
                cancelar            = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request/write
    initial begin
        esc_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_listo)
                    chk("ocupado_tras_listo", {31'd0, ocupado}, 32'd0);
                prev_listo = listo;
                if (listo)
                    listo_cnt++;
                if (bus.solicitud_lectura) begin
                    if (exp_dir.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL solicitud_extra: got %h expected none",
                                 bus.direccion_lectura);
                    end else begin
                        chk("direccion", {22'd0, bus.direccion_lectura},
                            {22'd0, exp_dir.pop_front()});
                    end
                end
                if (bus.escritura_buffer) begin
                    if (exp_esc.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL escritura_extra: got %h expected none",
                                 bus.datos_buffer);
                    end else begin
                        e = exp_esc.pop_front();
                        chk("datos_buffer", bus.datos_buffer, e.d);
                        chk("seleccion", {29'd0, bus.seleccion_buffer},
                            {29'd0, e.s});
                    end
                end
            end else begin
                prev_listo = 1'b0;
            end
        end
    end

    // Pulse inicio, then scramble the configuration inputs
    task automatic start(logic [9:0] d, logic [23:0] n, logic [2:0] b);
        @(posedge clk);
        #1;
        dir_ini  = d;
        cantidad = n;
        nbuf     = b;
        inicio   = 1'b1;
        @(posedge clk);
        #1;
        inicio   = 1'b0;
        dir_ini  = 10'h155;
        cantidad = 24'd2;
        nbuf     = 3'd7;
    endtask

    task automatic wait_idle(string nm);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!ocupado)
                return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL %s_timeout: got busy expected idle", nm);
    endtask

    task automatic fin_escenario(string nm);
        repeat (2) @(negedge clk);
        chk({nm, "_dir_pend"}, exp_dir.size(), 0);
        chk({nm, "_esc_pend"}, exp_esc.size(), 0);
        chk({nm, "_listo"}, listo_cnt, listo_exp);
    endtask

    int s3[8] = '{0, 0, 1, 1, 2, 2, 0, 0};

    initial begin
        bus.buffer_lleno = 1'b0;
        #2;
        chk("rst_sol", {31'd0, bus.solicitud_lectura}, 0);
        chk("rst_dir", {22'd0, bus.direccion_lectura}, 0);
        chk("rst_esc", {31'd0, bus.escritura_buffer}, 0);
        chk("rst_ocupado", {31'd0, ocupado}, 0);
        chk("rst_listo", {31'd0, listo}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 1: 0x3F0, 4 reads, 1 buffer
        for (int i = 0; i < 4; i++)
            push(10'h3F0 + 10'(i), 3'd0);
        listo_exp++;
        start(10'h3F0, 24'd4, 3'd1);
        wait_idle("s1");
        fin_escenario("s1");

        // 2: address wrap, buffer count 0, ignored inicio while busy
        push(10'h3FE, 3'd0);
        push(10'h3FF, 3'd0);
        push(10'h000, 3'd0);
        push(10'h001, 3'd0);
        listo_exp++;
        start(10'h3FE, 24'd4, 3'd0);
        @(posedge clk);
        #1;
        dir_ini  = 10'h123;
        cantidad = 24'd1;
        inicio   = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        wait_idle("s2");
        fin_escenario("s2");

        // 3: 2 words per line, 3 buffers, 8 reads
        for (int i = 0; i < 8; i++)
            push(10'h010 + 10'(i), 3'(s3[i]));
        listo_exp++;
        start(10'h010, 24'd8, 3'd3);
        wait_idle("s3");
        fin_escenario("s3");

        // 4: zero reads; inicio cycle then listo on the following cycle
        listo_exp++;
        start(10'h080, 24'd0, 3'd1);
        chk("s4_listo_on", {31'd0, listo}, 1);
        chk("s4_ocupado_fin", {31'd0, ocupado}, 1);
        @(posedge clk);
        #1;
        chk("s4_listo_off", {31'd0, listo}, 0);
        chk("s4_ocupado_off", {31'd0, ocupado}, 0);
        fin_escenario("s4");

        // 5: buffer full for 5 cycles in SOLICITAR
        for (int i = 0; i < 6; i++)
            push(10'h100 + 10'(i), 3'd0);
        listo_exp++;
        bus.buffer_lleno = 1'b1;
        start(10'h100, 24'd6, 3'd1);
        for (int i = 0; i < 5; i++) begin
            chk("s5_sin_sol", {31'd0, bus.solicitud_lectura}, 0);
            chk("s5_ocupado", {31'd0, ocupado}, 1);
            @(posedge clk);
            #1;
        end
        bus.buffer_lleno = 1'b0;
        wait_idle("s5");
        fin_escenario("s5");

        // 6a: cancel together with the 3rd data beat
        push(10'h200, 3'd0);
        push(10'h201, 3'd0);
        exp_dir.push_back(10'h202);
        cancel_at = rd_idx + 2;
        start(10'h200, 24'd5, 3'd1);
        wait_idle("s6");
        cancel_at = -1;
        chk("s6_reposo", {31'd0, ocupado}, 0);
        fin_escenario("s6");

        // 6b: asynchronous reset in the middle of a transfer
        mon_en = 1'b0;
        start(10'h040, 24'd20, 3'd3);
        repeat (9) @(posedge clk);
        #1;
        chk("s6_en_curso", {31'd0, ocupado}, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("r_sol", {31'd0, bus.solicitud_lectura}, 0);
        chk("r_dir", {22'd0, bus.direccion_lectura}, 0);
        chk("r_esc", {31'd0, bus.escritura_buffer}, 0);
        chk("r_datos", bus.datos_buffer, 0);
        chk("r_sel", {29'd0, bus.seleccion_buffer}, 0);
        chk("r_ocupado", {31'd0, ocupado}, 0);
        chk("r_listo", {31'd0, listo}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_ocupado", {31'd0, ocupado}, 0);
        chk("post_dir", {22'd0, bus.direccion_lectura}, 0);
        chk("post_sel", {29'd0, bus.seleccion_buffer}, 0);
        chk("post_listo_cnt", listo_cnt, listo_exp);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected end of test");
        $fatal(1);
    end

endmodule
